frog_game_sequencer: RTL and testbench

Top-level game-flow controller for the frogger design. It sequences the frog datapath and car movers through idle, play, death-freeze, level-up, game-over and win phases. It issues the `reset_frog` pulse consumed by the frog controller and gates car motion with `car_enable`. It also tracks the level and score shown by the display path.

---
 rtl/frog_game_sequencer.sv | 128 ++++++++++++
 tb/tb_frog_game_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/frog_game_sequencer.sv
// rtl/frog_game_sequencer.sv - frogger game-flow FSM: play, freezes, level/score tracking
module frog_game_sequencer #(
  parameter int DEATH_CYCLES = 25_000_000,
  parameter int LEVEL_CYCLES = 12_500_000,
  parameter int MAX_LEVEL    = 7,
  parameter int TIMER_W      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       collision_detected,
  input  logic       frog_at_top,
  input  logic [1:0] lives,
  output logic       reset_frog,
  output logic       car_enable,
  output logic [2:0] level,
  output logic [7:0] score,
  output logic [2:0] state,
  output logic       game_over,
  output logic       game_won
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DYING     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4,
    S_WIN       = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         level_d;
  logic [7:0]         score_d;
  logic               reset_frog_d;
  logic               start_prev, coll_prev;
  logic               start_rise, coll_rise;
  logic [8:0]         score_sum;

  assign start_rise = start_btn & ~start_prev;
  assign coll_rise  = collision_detected & ~coll_prev;
  assign score_sum  = {1'b0, score} + {6'b0, level} + 9'd1;
  assign state      = state_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    level_d      = level;
    score_d      = score;
    reset_frog_d = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (start_rise) begin
          state_d      = S_PLAY;
          level_d      = 3'd0;
          score_d      = 8'd0;
          reset_frog_d = 1'b1;
        end
      end
      S_PLAY: begin
        // Collision wins over reaching the top in the same cycle.
        if (coll_rise) begin
          state_d = S_DYING;
          timer_d = TIMER_W'(DEATH_CYCLES - 1);
        end else if (frog_at_top) begin
          state_d = S_LEVEL_UP;
          timer_d = TIMER_W'(LEVEL_CYCLES - 1);
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        end
      end
      S_DYING: begin
        if (timer_q == '0) begin
          if (lives == 2'd0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d      = S_PLAY;
            reset_frog_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_LEVEL_UP: begin
        if (timer_q == '0) begin
          if (level == 3'(MAX_LEVEL)) begin
            state_d = S_WIN;
          end else begin
            state_d      = S_PLAY;
            level_d      = level + 3'd1;
            reset_frog_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      level      <= 3'd0;
      score      <= 8'd0;
      reset_frog <= 1'b0;
      car_enable <= 1'b0;
      game_over  <= 1'b0;
      game_won   <= 1'b0;
      // Held high so a button already down at reset release is not an edge.
      start_prev <= 1'b1;
      coll_prev  <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      level      <= level_d;
      score      <= score_d;
      reset_frog <= reset_frog_d;
      car_enable <= (state_d == S_PLAY);
      game_over  <= (state_d == S_GAME_OVER);
      game_won   <= (state_d == S_WIN);
      start_prev <= start_btn;
      coll_prev  <= collision_detected;
    end
  end

endmodule

// File: tb/tb_frog_game_sequencer.sv
// tb/tb_frog_game_sequencer.sv - vector table and scoreboard bench for frog_game_sequencer
module tb_frog_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn, collision_detected, frog_at_top;
  logic [1:0] lives;
  logic       reset_frog, car_enable, game_over, game_won;
  logic [2:0] level, state;
  logic [7:0] score;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frog_game_sequencer #(
    .DEATH_CYCLES(4),
    .LEVEL_CYCLES(3),
    .MAX_LEVEL(2),
    .TIMER_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_btn(start_btn),
    .collision_detected(collision_detected),
    .frog_at_top(frog_at_top),
    .lives(lives),
    .reset_frog(reset_frog),
    .car_enable(car_enable),
    .level(level),
    .score(score),
    .state(state),
    .game_over(game_over),
    .game_won(game_won)
  );

  typedef struct {
    logic       s, c, t;
    logic [1:0] lv;
    logic [2:0] st;
    logic       rf, ce;
    logic [2:0] lvl;
    logic [7:0] sc;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       rf, ce, go, gw;
    logic [2:0] lvl;
    logic [7:0] sc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic s, logic c, logic t, logic [1:0] lv, logic [2:0] st,
                              logic rf, logic ce, logic [2:0] lvl, logic [7:0] sc);
    vec_t v;
    v.s = s; v.c = c; v.t = t; v.lv = lv;
    v.st = st; v.rf = rf; v.ce = ce; v.lvl = lvl; v.sc = sc;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(int idx, exp_t e);
    check("state", idx, {5'b0, state}, {5'b0, e.st});
    check("reset_frog", idx, {7'b0, reset_frog}, {7'b0, e.rf});
    check("car_enable", idx, {7'b0, car_enable}, {7'b0, e.ce});
    check("game_over", idx, {7'b0, game_over}, {7'b0, e.go});
    check("game_won", idx, {7'b0, game_won}, {7'b0, e.gw});
    check("level", idx, {5'b0, level}, {5'b0, e.lvl});
    check("score", idx, score, e.sc);
  endtask

  initial begin
    exp_t e, zero;
    zero.st = 3'd0; zero.rf = 0; zero.ce = 0; zero.go = 0; zero.gw = 0;
    zero.lvl = 0; zero.sc = 0;

    // start held through reset, released, then a real press
    vecs.push_back(mk(1,0,0,2, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,2, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,2, 1,1,1,0,0));
    vecs.push_back(mk(0,0,0,2, 1,0,1,0,0));
    vecs.push_back(mk(1,0,0,2, 1,0,1,0,0));
    // collision with lives left: 4 frozen cycles then reset_frog
    vecs.push_back(mk(0,1,0,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 1,1,1,0,0));
    vecs.push_back(mk(0,0,0,2, 1,0,1,0,0));
    // collision and top together
    vecs.push_back(mk(0,1,1,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 2,0,0,0,0));
    vecs.push_back(mk(0,0,0,2, 1,1,1,0,0));
    // three level-ups, collision ignored while frozen
    vecs.push_back(mk(0,0,1,2, 3,0,0,0,1));
    vecs.push_back(mk(0,1,0,2, 3,0,0,0,1));
    vecs.push_back(mk(0,0,0,2, 3,0,0,0,1));
    vecs.push_back(mk(0,0,0,2, 1,1,1,1,1));
    vecs.push_back(mk(0,0,1,2, 3,0,0,1,3));
    vecs.push_back(mk(0,0,0,2, 3,0,0,1,3));
    vecs.push_back(mk(0,0,0,2, 3,0,0,1,3));
    vecs.push_back(mk(0,0,0,2, 1,1,1,2,3));
    vecs.push_back(mk(0,0,1,2, 3,0,0,2,6));
    vecs.push_back(mk(0,0,0,2, 3,0,0,2,6));
    vecs.push_back(mk(0,0,0,2, 3,0,0,2,6));
    vecs.push_back(mk(0,0,0,2, 5,0,0,2,6));
    vecs.push_back(mk(0,1,1,2, 5,0,0,2,6));
    vecs.push_back(mk(0,0,0,2, 5,0,0,2,6));
    // restart from WIN, one level-up, then death on last life
    vecs.push_back(mk(1,0,0,2, 1,1,1,0,0));
    vecs.push_back(mk(0,0,0,2, 1,0,1,0,0));
    vecs.push_back(mk(0,0,1,2, 3,0,0,0,1));
    vecs.push_back(mk(0,0,0,2, 3,0,0,0,1));
    vecs.push_back(mk(0,0,0,2, 3,0,0,0,1));
    vecs.push_back(mk(0,0,0,2, 1,1,1,1,1));
    vecs.push_back(mk(0,1,0,0, 2,0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 2,0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 2,0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 2,0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 4,0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 4,0,0,1,1));
    vecs.push_back(mk(1,0,0,0, 1,1,1,0,0));
    vecs.push_back(mk(0,0,0,3, 1,0,1,0,0));
    vecs.push_back(mk(0,0,1,3, 3,0,0,0,1));
    vecs.push_back(mk(0,0,0,3, 3,0,0,0,1));

    rst_n = 1'b0;
    start_btn = 1'b1;
    collision_detected = 1'b0;
    frog_at_top = 1'b0;
    lives = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, zero);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      if (i > 0) @(negedge clk);
      start_btn = vecs[i].s;
      collision_detected = vecs[i].c;
      frog_at_top = vecs[i].t;
      lives = vecs[i].lv;
      e.st = vecs[i].st; e.rf = vecs[i].rf; e.ce = vecs[i].ce;
      e.go = (vecs[i].st == 3'd4); e.gw = (vecs[i].st == 3'd5);
      e.lvl = vecs[i].lvl; e.sc = vecs[i].sc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(i, e);
    end

    // asynchronous reset two cycles into a LEVEL_UP freeze
    @(negedge clk);
    frog_at_top = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all(100, zero);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_all(101 + k, zero);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
